// File: rtl/simple_proc_ctrl.sv
// simple_proc_ctrl: instruction-side sequencer for simple_proc_alu.
// Fetches 20-bit instructions over a req/valid handshake and decodes them.
// Reads an 8x16 register file, issues opcode/operands to the ALU, writes
// back the registered ALU result and resolves branches from the ALU flags.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start               begin execution at PC=0 (honoured in IDLE/HALT)
//   halted              high while in HALT
//   imem_req/addr       fetch request and address (= PC)
//   imem_valid/rdata    fetch response
//   alu_*  (out)        opcode, imm7 and operands to the ALU
//   alu_*  (in)         registered ALU result and N/Z/C/V flags
//   dbg_sel/dbg_data    combinational register-file read port
module simple_proc_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        halted,
  output logic        imem_req,
  output logic [6:0]  imem_addr,
  input  logic        imem_valid,
  input  logic [19:0] imem_rdata,
  output logic [3:0]  alu_opcode,
  output logic [6:0]  alu_immediate_offset,
  output logic [15:0] alu_operand_1,
  output logic [15:0] alu_operand_2,
  input  logic [15:0] alu_result,
  input  logic        alu_overflow,
  input  logic        alu_carry,
  input  logic        alu_negative,
  input  logic        alu_zero,
  input  logic [2:0]  dbg_sel,
  output logic [15:0] dbg_data
);

  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned PC_W     = 7;
  localparam int unsigned OP_W     = 4;
  localparam int unsigned REG_W    = 3;

  localparam logic [OP_W-1:0] OP_LAST_ALU = 4'd12;
  localparam logic [OP_W-1:0] OP_CMP      = 4'd11;
  localparam logic [OP_W-1:0] OP_BR       = 4'd13;
  localparam logic [OP_W-1:0] OP_NOP      = 4'd14;
  localparam logic [OP_W-1:0] OP_HLT      = 4'd15;
  // Idle opcode: the ALU never updates flags on it
  localparam logic [OP_W-1:0] OP_IDLE     = 4'hE;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rn;
    logic [REG_W-1:0] rm;
    logic [PC_W-1:0]  imm;
  } instr_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_WB    = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [REG_W-1:0]    rd_q, rd_d;
  logic [PC_W-1:0]     imm_q, imm_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic                halted_q, halted_d;
  logic                imem_req_q, imem_req_d;
  logic [OP_W-1:0]     alu_op_q, alu_op_d;
  logic [PC_W-1:0]     alu_imm_q, alu_imm_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;

  instr_t              fetched;
  logic                br_taken;

  assign fetched = instr_t'(imem_rdata);

  // Branch condition; rd field carries cond, flags come straight from the ALU
  always_comb begin
    br_taken = 1'b0;
    case (rd_q)
      3'd0: br_taken = 1'b1;
      3'd1: br_taken = alu_zero;
      3'd2: br_taken = !alu_zero;
      3'd3: br_taken = (alu_negative == alu_overflow);
      3'd4: br_taken = (alu_negative != alu_overflow);
      3'd5: br_taken = alu_carry;
      3'd6: br_taken = !alu_carry;
      3'd7: br_taken = alu_negative;
      default: br_taken = 1'b0;
    endcase
  end

  // Next-state, datapath and output-register logic
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    op_d      = op_q;
    rd_d      = rd_q;
    imm_d     = imm_q;
    regs_d    = regs_q;
    alu_op_d  = OP_IDLE;
    alu_imm_d = '0;
    alu_a_d   = '0;
    alu_b_d   = '0;

    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (imem_valid) begin
          op_d      = fetched.op;
          rd_d      = fetched.rd;
          imm_d     = fetched.imm;
          // ALU drive is registered so it is stable for the whole EXEC cycle
          alu_op_d  = fetched.op;
          alu_imm_d = fetched.imm;
          alu_a_d   = regs_q[fetched.rn];
          alu_b_d   = regs_q[fetched.rm];
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        if (op_q <= OP_LAST_ALU) begin
          state_d = S_WB;
        end else if (op_q == OP_BR) begin
          pc_d    = br_taken ? imm_q : pc_q + PC_W'(1);
          state_d = S_FETCH;
        end else if (op_q == OP_NOP) begin
          pc_d    = pc_q + PC_W'(1);
          state_d = S_FETCH;
        end else if (op_q == OP_HLT) begin
          state_d = S_HALT;
        end
      end
      S_WB: begin
        if (op_q != OP_CMP) begin
          regs_d[rd_q] = alu_result;
        end
        pc_d    = pc_q + PC_W'(1);
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase

    imem_req_d = (state_d == S_FETCH);
    halted_d   = (state_d == S_HALT);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      imm_q      <= '0;
      regs_q     <= '{default: '0};
      halted_q   <= 1'b0;
      imem_req_q <= 1'b0;
      alu_op_q   <= OP_IDLE;
      alu_imm_q  <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      imm_q      <= imm_d;
      regs_q     <= regs_d;
      halted_q   <= halted_d;
      imem_req_q <= imem_req_d;
      alu_op_q   <= alu_op_d;
      alu_imm_q  <= alu_imm_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
    end
  end

  assign halted               = halted_q;
  assign imem_req             = imem_req_q;
  assign imem_addr            = pc_q;
  assign alu_opcode           = alu_op_q;
  assign alu_immediate_offset = alu_imm_q;
  assign alu_operand_1        = alu_a_q;
  assign alu_operand_2        = alu_b_q;
  assign dbg_data             = regs_q[dbg_sel];

endmodule

// File: tb/tb_simple_proc_ctrl.sv
// Bench for simple_proc_ctrl: behavioural ALU and instruction memory around the
// controller, and an instruction-level interpreter as the reference model.
module tb_simple_proc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        halted;
  logic        imem_req;
  logic [6:0]  imem_addr;
  logic        imem_valid;
  logic [19:0] imem_rdata;
  logic [3:0]  alu_opcode;
  logic [6:0]  alu_immediate_offset;
  logic [15:0] alu_operand_1, alu_operand_2;
  logic [15:0] alu_result;
  logic        alu_overflow, alu_carry, alu_negative, alu_zero;
  logic [2:0]  dbg_sel;
  logic [15:0] dbg_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  simple_proc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halted(halted),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid),
    .imem_rdata(imem_rdata), .alu_opcode(alu_opcode),
    .alu_immediate_offset(alu_immediate_offset),
    .alu_operand_1(alu_operand_1), .alu_operand_2(alu_operand_2),
    .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_carry(alu_carry),
    .alu_negative(alu_negative), .alu_zero(alu_zero),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  // ALU semantics: returns {V, C, N, Z, result}
  function automatic logic [19:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic [6:0] imm);
    int ua, ub, sa, sb, u, s;
    logic [15:0] r;
    logic c, v;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    r = 16'h0; c = 1'b0; v = 1'b0; u = 0; s = 0;
    case (op)
      4'd0: begin u = ua + ub; r = 16'(u); c = (u > 65535); s = sa + sb; v = (s > 32767) || (s < -32768); end
      4'd1, 4'd11: begin r = 16'(ua - ub); c = (ua >= ub); s = sa - sb; v = (s > 32767) || (s < -32768); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: r = 16'(imm);
      4'd7: begin u = ua + int'(imm); r = 16'(u); c = (u > 65535); s = sa + int'(imm); v = (s > 32767); end
      4'd8: begin r = {a[14:0], 1'b0}; c = a[15]; end
      4'd9: begin r = {1'b0, a[15:1]}; c = a[0]; end
      4'd10: r = a;
      4'd12: begin u = ua + 1; r = 16'(u); c = (u > 65535); s = sa + 1; v = (s > 32767); end
      default: r = 16'h0;
    endcase
    return {v, c, r[15], (r == 16'h0), r};
  endfunction

  // Behavioural ALU: one-cycle registered result/flags, held for opcodes 13..15
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {alu_overflow, alu_carry, alu_negative, alu_zero, alu_result} <= 20'h0;
    end else if (alu_opcode <= 4'd12) begin
      {alu_overflow, alu_carry, alu_negative, alu_zero, alu_result} <=
        alu_fn(alu_opcode, alu_operand_1, alu_operand_2, alu_immediate_offset);
    end
  end

  // Instruction memory: valid arrives (2 + mem_delay) negedges into a request
  logic [19:0] mem [128];
  int mem_delay = 0;
  int mem_cnt   = 0;
  always @(negedge clk) begin
    imem_rdata = mem[imem_addr];
    if (imem_req) begin
      mem_cnt++;
      imem_valid = (mem_cnt >= 2 + mem_delay);
    end else begin
      mem_cnt = 0;
      imem_valid = 1'b0;
    end
  end

  // Fetch-address trace and ALU-quiet-during-fetch monitor
  logic [6:0] obs_trace [$];
  logic       req_prev = 1'b0;
  int         fetch_alu_bad = 0;
  always @(negedge clk) begin
    if (imem_req && !req_prev) obs_trace.push_back(imem_addr);
    if (imem_req && alu_opcode !== 4'hE) fetch_alu_bad++;
    req_prev = imem_req;
  end

  // Reference model state (architectural only)
  logic [15:0] m_regs [8];
  logic [3:0]  m_flags;   // {V, C, N, Z}
  logic [6:0]  exp_trace [$];

  function automatic logic [19:0] enc(input int op, input int rd, input int rn,
                                      input int rm, input int imm);
    return {4'(op), 3'(rd), 3'(rn), 3'(rm), 7'(imm)};
  endfunction

  function automatic bit cond_ok(input logic [2:0] cond, input logic [3:0] f);
    logic v, c, n, z;
    {v, c, n, z} = f;
    case (cond)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return n == v;
      3'd4: return n != v;
      3'd5: return c;
      3'd6: return !c;
      default: return n;
    endcase
  endfunction

  // Interpret the program in mem from address 0; returns cycles from FETCH entry to HALT
  task automatic model_run(output int cycles);
    int pc;
    logic [19:0] ins;
    logic [19:0] r;
    int op, rd, rn, rm, imm;
    pc = 0; cycles = 0;
    exp_trace.delete();
    for (int step = 0; step < 2000; step++) begin
      exp_trace.push_back(7'(pc));
      ins = mem[pc];
      op = int'(ins[19:16]); rd = int'(ins[15:13]); rn = int'(ins[12:10]);
      rm = int'(ins[9:7]);   imm = int'(ins[6:0]);
      cycles += 2 + mem_delay;
      if (op <= 12) begin
        r = alu_fn(4'(op), m_regs[rn], m_regs[rm], 7'(imm));
        m_flags = r[19:16];
        if (op != 11) m_regs[rd] = r[15:0];
        cycles += 2;
        pc = (pc + 1) % 128;
      end else if (op == 13) begin
        cycles += 1;
        pc = cond_ok(3'(rd), m_flags) ? imm : (pc + 1) % 128;
      end else if (op == 14) begin
        cycles += 1;
        pc = (pc + 1) % 128;
      end else begin
        cycles += 1;
        break;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_sel = 3'(i);
      #1;
      check($sformatf("%s_R%0d", tag, i), 32'(dbg_data), 32'(m_regs[i]));
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 128; i++) mem[i] = enc(15, 0, 0, 0, 0);
  endtask

  // Run the loaded program from start until HALT and compare against the model
  task automatic run_prog(input string tag, input int delay);
    int exp_cyc, n;
    bit done;
    mem_delay = delay;
    model_run(exp_cyc);
    @(negedge clk);
    obs_trace.delete();
    start = 1'b1;
    n = 0; done = 1'b0;
    while (!done && n < 5000) begin
      @(posedge clk);
      n++;
      #1;
      start = 1'b0;
      if (halted) done = 1'b1;
    end
    check({tag, "_halt_reached"}, 32'(done), 32'd1);
    if (done) check({tag, "_cycles"}, 32'(n - 1), 32'(exp_cyc));
    check({tag, "_trace_len"}, 32'(obs_trace.size()), 32'(exp_trace.size()));
    for (int i = 0; i < exp_trace.size() && i < obs_trace.size(); i++)
      check($sformatf("%s_fetch%0d", tag, i), 32'(obs_trace[i]), 32'(exp_trace[i]));
    check_regs(tag);
  endtask

  task automatic gen_random(input int len);
    int kind;
    clear_mem();
    for (int i = 0; i < len; i++) begin
      kind = int'($urandom_range(0, 11));
      if (kind <= 9)
        mem[i] = enc(int'($urandom_range(0, 12)), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 127)));
      else if (kind == 11 && i <= len - 2)
        mem[i] = enc(13, int'($urandom_range(0, 7)), 0, 0, i + 2);
      else
        mem[i] = enc(14, 0, 0, 0, 0);
    end
  endtask

  initial begin
    int n;
    bit seen;
    rst_n = 1'b0; start = 1'b0; dbg_sel = 3'd0; imem_valid = 1'b0; imem_rdata = 20'h0;
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
    m_flags = 4'h0;
    clear_mem();
    #23;
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_alu_opcode", 32'(alu_opcode), 32'hE);
    check("rst_alu_imm", 32'(alu_immediate_offset), 32'd0);
    check("rst_alu_op1", 32'(alu_operand_1), 32'd0);
    check("rst_alu_op2", 32'(alu_operand_2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_regs("rst");

    // Basic program, single-cycle memory then stalled memory
    mem[0] = enc(6, 1, 0, 0, 5);
    mem[1] = enc(6, 2, 0, 0, 3);
    mem[2] = enc(0, 3, 1, 2, 0);
    mem[3] = enc(15, 0, 0, 0, 0);
    run_prog("basic", 0);
    dbg_sel = 3'd3; #1;
    check("basic_R3_sum", 32'(dbg_data), 32'd8);
    fetch_alu_bad = 0;
    run_prog("stall", 3);
    check("stall_alu_idle_in_fetch", 32'(fetch_alu_bad), 32'd0);

    // BEQ taken / not taken
    clear_mem();
    mem[0] = enc(6, 1, 0, 0, 7);
    mem[1] = enc(6, 2, 0, 0, 7);
    mem[2] = enc(11, 0, 1, 2, 0);
    mem[3] = enc(13, 1, 0, 0, 10);
    run_prog("beq_t", 0);
    if (obs_trace.size() > 4) check("beq_t_target", 32'(obs_trace[4]), 32'd10);
    mem[1] = enc(6, 2, 0, 0, 6);
    run_prog("beq_nt", 1);
    if (obs_trace.size() > 4) check("beq_nt_target", 32'(obs_trace[4]), 32'd4);

    // Signed compare: BLT taken, BGE not taken
    clear_mem();
    mem[0] = enc(6, 1, 0, 0, 0);
    mem[1] = enc(6, 2, 0, 0, 1);
    mem[2] = enc(1, 4, 1, 2, 0);
    mem[3] = enc(11, 0, 4, 2, 0);
    mem[4] = enc(13, 4, 0, 0, 20);
    run_prog("blt", 0);
    dbg_sel = 3'd4; #1;
    check("blt_R4", 32'(dbg_data), 32'hFFFF);
    if (obs_trace.size() > 5) check("blt_target", 32'(obs_trace[5]), 32'd20);
    mem[4] = enc(13, 3, 0, 0, 20);
    run_prog("bge", 0);
    if (obs_trace.size() > 5) check("bge_target", 32'(obs_trace[5]), 32'd5);

    // PC wrap through a NOP at 127
    clear_mem();
    mem[0] = enc(6, 6, 0, 0, 1);
    run_prog("wrap_setup", 0);
    clear_mem();
    mem[0]   = enc(6, 5, 0, 0, 2);
    mem[1]   = enc(11, 0, 6, 5, 0);
    mem[2]   = enc(13, 1, 0, 0, 4);
    mem[3]   = enc(13, 0, 0, 0, 126);
    mem[126] = enc(6, 6, 0, 0, 2);
    mem[127] = enc(14, 0, 0, 0, 0);
    run_prog("wrap", 0);
    if (obs_trace.size() > 6) check("wrap_after_127", 32'(obs_trace[6]), 32'd0);

    // HALT is held with no fetching
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check($sformatf("hold_halted%0d", i), 32'(halted), 32'd1);
      check($sformatf("hold_req%0d", i), 32'(imem_req), 32'd0);
    end

    // Restart keeps the register file
    clear_mem();
    mem[0] = enc(10, 7, 6, 0, 0);
    run_prog("restart", 0);
    dbg_sel = 3'd7; #1;
    check("restart_R7_retained", 32'(dbg_data), 32'd2);

    // Randomized programs with random memory latency
    for (int p = 0; p < 6; p++) begin
      gen_random(12);
      run_prog($sformatf("rand%0d", p), int'($urandom_range(0, 2)));
    end

    // Reset during EXEC of ADD R5 aborts it
    clear_mem();
    mem[0] = enc(6, 1, 0, 0, 9);
    mem[1] = enc(0, 5, 1, 1, 0);
    mem[2] = enc(15, 0, 0, 0, 0);
    mem_delay = 0;
    @(negedge clk);
    obs_trace.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (alu_opcode == 4'd0) seen = 1'b1;
    end
    check("rstx_exec_add_seen", 32'(seen), 32'd1);
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
    m_flags = 4'h0;
    #1;
    check("rstx_imem_req", 32'(imem_req), 32'd0);
    check("rstx_alu_opcode", 32'(alu_opcode), 32'hE);
    check("rstx_halted", 32'(halted), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("rstx_idle_req%0d", i), 32'(imem_req), 32'd0);
      check($sformatf("rstx_idle_halted%0d", i), 32'(halted), 32'd0);
    end
    dbg_sel = 3'd5; #1;
    check("rstx_R5", 32'(dbg_data), 32'd0);
    check_regs("rstx");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
